// File: rtl/hex_memory.sv
// hex_memory: unified program/data memory with byte-stream boot loader.
// The loader fills memory from a host link while the processor is held in reset.
// After the load completes, the block serves combinational byte fetches and word
// loads, and synchronous word stores.
// Optional feature: define HEX_MEMORY_BOUNDS_CHECK_EN to get a sticky o_err flag
// for out-of-range accesses. With it, out-of-range writes are suppressed and
// out-of-range reads return 0. Without it, addresses wrap and o_err is tied 0.
module hex_memory #(
   parameter int unsigned DEPTH_WORDS = 65536
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_ld_valid,
   input  logic [7:0]  i_ld_data,
   output logic        o_ld_ready,
   output logic        o_ld_done,
   output logic        o_cpu_rst,
   input  logic        i_f_valid,
   input  logic [20:0] i_f_addr,
   output logic [7:0]  o_f_data,
   input  logic        i_d_valid,
   input  logic        i_d_we,
   input  logic [18:0] i_d_addr,
   input  logic [31:0] i_d_data,
   output logic [31:0] o_d_data,
   output logic        o_err
);

   localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   typedef enum logic [1:0] {ST_LEN, ST_DATA, ST_DONE} state_t;

   state_t      state_q, state_d;
   logic [1:0]  hdr_q, hdr_d;
   logic [31:0] len_q, len_d;
   logic [31:0] cnt_q, cnt_d;
   logic        done_q;
   logic        cpu_rst_q;
   logic        ld_fire;
   logic        ld_wr;

   logic [31:0] mem [DEPTH_WORDS];

   logic [AW-1:0] ld_idx, f_idx, d_idx;
   logic [1:0]    ld_lane;
   logic [31:0]   f_word;
   logic          ld_oor, f_oor, d_oor;

   assign o_ld_ready = (state_q != ST_DONE);
   assign ld_fire    = i_ld_valid & o_ld_ready;
   assign o_ld_done  = done_q;
   assign o_cpu_rst  = cpu_rst_q;

   assign ld_idx  = cnt_q[AW+1:2];
   assign ld_lane = cnt_q[1:0];
   assign f_idx   = i_f_addr[AW+1:2];
   assign d_idx   = i_d_addr[AW-1:0];

`ifdef HEX_MEMORY_BOUNDS_CHECK_EN
   logic err_q;

   assign ld_oor = ({2'b00, cnt_q[31:2]} >= DEPTH_WORDS);
   assign f_oor  = (32'(i_f_addr[20:2]) >= DEPTH_WORDS);
   assign d_oor  = (32'(i_d_addr) >= DEPTH_WORDS);
   assign o_err  = err_q;

   // Sticky out-of-range flag, cleared only by reset.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         err_q <= 1'b0;
      end else if ((ld_wr & ld_oor) | (i_f_valid & f_oor) | (i_d_valid & d_oor)) begin
         err_q <= 1'b1;
      end
   end
`else
   logic unused_addr_bits;

   assign ld_oor = 1'b0;
   assign f_oor  = 1'b0;
   assign d_oor  = 1'b0;
   assign o_err  = 1'b0;
   // Upper address bits and the fetch valid only matter for bounds checking.
   assign unused_addr_bits = ^{i_f_valid, i_f_addr, i_d_addr, cnt_q};
`endif

   // Loader next-state: gather the little-endian length, then count data bytes.
   always_comb begin
      state_d = state_q;
      hdr_d   = hdr_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      ld_wr   = 1'b0;
      case (state_q)
         ST_LEN: begin
            if (ld_fire) begin
               len_d[{hdr_q, 3'b000} +: 8] = i_ld_data;
               hdr_d = hdr_q + 2'd1;
               if (hdr_q == 2'd3) begin
                  state_d = ({i_ld_data, len_q[23:0]} == '0) ? ST_DONE : ST_DATA;
               end
            end
         end
         ST_DATA: begin
            if (ld_fire) begin
               ld_wr = 1'b1;
               cnt_d = cnt_q + 32'd1;
               if (cnt_q == len_q - 32'd1) begin
                  state_d = ST_DONE;
               end
            end
         end
         default: begin
         end
      endcase
   end

   // Loader state and counters; done/cpu-reset flags follow the next state so
   // they change on the same edge that accepts the final byte.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= ST_LEN;
         hdr_q     <= '0;
         len_q     <= '0;
         cnt_q     <= '0;
         done_q    <= 1'b0;
         cpu_rst_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         hdr_q     <= hdr_d;
         len_q     <= len_d;
         cnt_q     <= cnt_d;
         done_q    <= (state_d == ST_DONE);
         cpu_rst_q <= (state_d != ST_DONE);
      end
   end

   // Memory writes: loader byte lanes during load, full-word stores after it.
   always_ff @(posedge i_clk) begin
      if (ld_wr && !ld_oor) begin
         mem[ld_idx][{ld_lane, 3'b000} +: 8] <= i_ld_data;
      end else if (i_d_valid && i_d_we && done_q && !d_oor) begin
         mem[d_idx] <= i_d_data;
      end
   end

   // Combinational read ports.
   always_comb begin
      f_word   = mem[f_idx];
      o_f_data = f_oor ? '0 : f_word[{i_f_addr[1:0], 3'b000} +: 8];
      o_d_data = d_oor ? '0 : mem[d_idx];
   end

endmodule

// File: tb/tb_hex_memory.sv
// Self-checking bench for hex_memory with a byte-array reference model.
module tb_hex_memory;

   localparam int unsigned DW = 16;
   localparam int unsigned NB = DW * 4;

`ifdef HEX_MEMORY_BOUNDS_CHECK_EN
   localparam bit BC = 1'b1;
`else
   localparam bit BC = 1'b0;
`endif

   logic        i_clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic        i_ld_valid = 1'b0;
   logic [7:0]  i_ld_data = '0;
   logic        o_ld_ready;
   logic        o_ld_done;
   logic        o_cpu_rst;
   logic        i_f_valid = 1'b0;
   logic [20:0] i_f_addr = '0;
   logic [7:0]  o_f_data;
   logic        i_d_valid = 1'b0;
   logic        i_d_we = 1'b0;
   logic [18:0] i_d_addr = '0;
   logic [31:0] i_d_data = '0;
   logic [31:0] o_d_data;
   logic        o_err;

   always #5 i_clk = ~i_clk;

   hex_memory #(.DEPTH_WORDS(DW)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .i_ld_valid(i_ld_valid), .i_ld_data(i_ld_data),
      .o_ld_ready(o_ld_ready), .o_ld_done(o_ld_done), .o_cpu_rst(o_cpu_rst),
      .i_f_valid(i_f_valid), .i_f_addr(i_f_addr), .o_f_data(o_f_data),
      .i_d_valid(i_d_valid), .i_d_we(i_d_we), .i_d_addr(i_d_addr),
      .i_d_data(i_d_data), .o_d_data(o_d_data), .o_err(o_err)
   );

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp, input logic [31:0] msk);
      n_cmp++;
      if ((((act ^ exp) & msk) != 0) || $isunknown(act & msk)) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (mask %h) at %0t", nm, act, exp, msk, $time);
      end
   endtask

   // Reference model: image = 4 length bytes then N data bytes; byte k -> address k.
   logic [7:0]  m_mem [NB];
   bit          m_known [NB];
   int unsigned m_nacc = 0;
   logic [31:0] m_len = '0;
   bit          m_err = 1'b0;
   bit          m_was_done;
   int unsigned m_k;

   initial for (int i = 0; i < NB; i++) m_known[i] = 1'b0;

   function automatic bit m_done();
      return (m_nacc >= 4) && ((m_nacc - 4) == m_len);
   endfunction

   always @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         m_nacc = 0;
         m_len  = '0;
         m_err  = 1'b0;
      end else begin
         m_was_done = m_done();
         if (BC && i_f_valid && (int'(i_f_addr) / 4) >= DW) m_err = 1'b1;
         if (BC && i_d_valid && int'(i_d_addr) >= DW) m_err = 1'b1;
         if (i_d_valid && i_d_we && m_was_done && !(BC && int'(i_d_addr) >= DW)) begin
            for (int l = 0; l < 4; l++) begin
               m_mem[(int'(i_d_addr) % DW) * 4 + l]   = i_d_data[8*l +: 8];
               m_known[(int'(i_d_addr) % DW) * 4 + l] = 1'b1;
            end
         end
         if (i_ld_valid && !m_was_done) begin
            if (m_nacc < 4) begin
               m_len[8*m_nacc +: 8] = i_ld_data;
            end else begin
               m_k = m_nacc - 4;
               if (BC && (m_k / 4) >= DW) begin
                  m_err = 1'b1;
               end else begin
                  m_mem[m_k % NB]   = i_ld_data;
                  m_known[m_k % NB] = 1'b1;
               end
            end
            m_nacc++;
         end
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   logic [31:0] e_d, k_d;
   int unsigned fa;
   always @(negedge i_clk) begin
      if (chk_en) begin
         chk("ld_ready", o_ld_ready, !m_done(), 1);
         chk("ld_done", o_ld_done, m_done(), 1);
         chk("cpu_rst", o_cpu_rst, !m_done(), 1);
         chk("err", o_err, m_err, 1);
         if (BC && (int'(i_f_addr) / 4) >= DW) begin
            chk("f_data_oor", o_f_data, 0, 32'hFF);
         end else begin
            fa = int'(i_f_addr) % NB;
            if (m_known[fa]) chk("f_data", o_f_data, m_mem[fa], 32'hFF);
         end
         if (BC && int'(i_d_addr) >= DW) begin
            chk("d_data_oor", o_d_data, 0, '1);
         end else begin
            e_d = '0;
            k_d = '0;
            for (int l = 0; l < 4; l++) begin
               e_d[8*l +: 8] = m_mem[(int'(i_d_addr) % DW) * 4 + l];
               k_d[8*l +: 8] = {8{m_known[(int'(i_d_addr) % DW) * 4 + l]}};
            end
            if (k_d != 0) chk("d_data", o_d_data, e_d, k_d);
         end
      end
   end

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      i_ld_valid = 1'b1;
      i_ld_data  = b;
      tick();
   endtask

   task automatic pulse_reset();
      i_rst_n = 1'b0;
      tick();
      chk("rst_ready", o_ld_ready, 1, 1);
      chk("rst_done", o_ld_done, 0, 1);
      chk("rst_cpu_rst", o_cpu_rst, 1, 1);
      chk("rst_err", o_err, 0, 1);
      i_rst_n = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   int unsigned nlen;
   initial begin
      repeat (2) tick();
      pulse_reset();
      chk_en = 1'b1;

      // Five-byte image, back to back.
      send(8'h05); send(8'h00); send(8'h00); send(8'h00);
      send(8'h31); send(8'h42); send(8'h53); send(8'h64);
      chk("done_before_last", o_ld_done, 0, 1);
      send(8'h75);
      i_ld_valid = 1'b0;
      chk("done_after_last", o_ld_done, 1, 1);
      chk("cpu_rst_after_last", o_cpu_rst, 0, 1);
      chk("ready_after_last", o_ld_ready, 0, 1);
      i_d_addr = 19'd0; i_f_addr = 21'd4; #1;
      chk("img_word0", o_d_data, 32'h64534231, '1);
      chk("img_byte4", o_f_data, 8'h75, 32'hFF);

      // Store after load.
      i_d_valid = 1'b1; i_d_we = 1'b1; i_d_addr = 19'd3; i_d_data = 32'hDEADBEEF;
      tick();
      i_d_valid = 1'b0; i_d_we = 1'b0;
      i_f_addr = 21'd12; #1;
      chk("st_word3", o_d_data, 32'hDEADBEEF, '1);
      chk("st_byte12", o_f_data, 8'hEF, 32'hFF);
      i_f_addr = 21'd15; #1;
      chk("st_byte15", o_f_data, 8'hDE, 32'hFF);

      // Zero words 0-1, then a partial load with stores attempted during DATA.
      pulse_reset();
      send(8'h08); send(8'h00); send(8'h00); send(8'h00);
      for (int i = 0; i < 8; i++) send(8'h00);
      i_ld_valid = 1'b0;
      pulse_reset();
      send(8'h05); send(8'h00); send(8'h00); send(8'h00);
      i_d_valid = 1'b1; i_d_we = 1'b1; i_d_addr = 19'd0; i_d_data = 32'hFFFFFFFF;
      send(8'h31); send(8'h42);
      i_ld_valid = 1'b0;
      i_d_valid = 1'b0; i_d_we = 1'b0; #1;
      chk("partial_word0", o_d_data, 32'h00004231, '1);
      pulse_reset();
      send(8'h01); send(8'h00); send(8'h00); send(8'h00); send(8'hAA);
      i_ld_valid = 1'b0; #1;
      chk("reload_word0", o_d_data, 32'h000042AA, '1);
      chk("reload_done", o_ld_done, 1, 1);

      // Zero-length image; later loader bytes must be ignored.
      pulse_reset();
      send(8'h00); send(8'h00); send(8'h00); send(8'h00);
      i_ld_valid = 1'b0;
      chk("len0_done", o_ld_done, 1, 1);
      chk("len0_ready", o_ld_ready, 0, 1);
      send(8'h77); send(8'h66);
      i_ld_valid = 1'b0; #1;
      chk("len0_ignored", o_d_data, 32'h000042AA, '1);

      // Out-of-range store to word 20.
      i_d_valid = 1'b1; i_d_we = 1'b1; i_d_addr = 19'd4; i_d_data = 32'hCAFEF00D;
      tick();
      i_d_addr = 19'd20; i_d_data = 32'h12345678;
      tick();
      i_d_valid = 1'b0; i_d_we = 1'b0; i_d_addr = 19'd4; #1;
`ifdef HEX_MEMORY_BOUNDS_CHECK_EN
      chk("oor_err", o_err, 1, 1);
      chk("oor_word4", o_d_data, 32'hCAFEF00D, '1);
`else
      chk("wrap_err", o_err, 0, 1);
      chk("wrap_word4", o_d_data, 32'h12345678, '1);
`endif

      // Random image slightly larger than the array, with idle gaps.
      pulse_reset();
      nlen = NB + $urandom_range(0, 8);
      send(nlen[7:0]); send(nlen[15:8]); send(nlen[23:16]); send(nlen[31:24]);
      for (int c = 0; c < 2000 && !m_done(); c++) begin
         i_ld_valid = ($urandom_range(0, 3) != 0);
         i_ld_data  = 8'($urandom);
         i_f_valid  = 1'($urandom);
         i_f_addr   = 21'($urandom_range(0, NB - 1));
         i_d_valid  = 1'($urandom);
         i_d_we     = 1'($urandom);
         i_d_addr   = 19'($urandom_range(0, DW - 1));
         i_d_data   = $urandom;
         tick();
      end
      chk("rand_load_done", o_ld_done, 1, 1);

      // Random traffic after load, including stray loader bytes.
      for (int c = 0; c < 400; c++) begin
         i_ld_valid = 1'($urandom);
         i_ld_data  = 8'($urandom);
         i_f_valid  = 1'($urandom);
         i_f_addr   = ($urandom_range(0, 15) == 0) ? 21'($urandom) : 21'($urandom_range(0, NB - 1));
         i_d_valid  = 1'($urandom);
         i_d_we     = 1'($urandom);
         i_d_addr   = ($urandom_range(0, 15) == 0) ? 19'($urandom_range(DW, 2 * DW - 1))
                                                   : 19'($urandom_range(0, DW - 1));
         i_d_data   = $urandom;
         tick();
      end
      i_ld_valid = 1'b0; i_f_valid = 1'b0; i_d_valid = 1'b0; i_d_we = 1'b0;
      tick();
      chk_en = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/hex_memory.md
# hex_memory

Unified program/data memory and boot loader that serves as the responder for the hex processor's fetch and data ports. A byte-stream loader FSM fills the memory from a host link while holding the processor in reset. Once the image is loaded, the FSM releases the processor. The block then serves combinational byte fetches and word loads, plus synchronous word stores.

## Interface

Parameters:
- `DEPTH_WORDS`, default 65536: memory depth in 32-bit words; must be a power of two, at most 2^19.

Ports:
- `i_clk`, in, 1: sole clock.
- `i_rst_n`, in, 1: asynchronous active-low reset.
- `i_ld_valid`, in, 1: loader byte valid.
- `i_ld_data`, in, 8: loader byte.
- `o_ld_ready`, out, 1: loader can accept a byte.
- `o_ld_done`, out, 1: image fully loaded.
- `o_cpu_rst`, out, 1: active-high reset to the processor (`i_rst`); held at 1 until the load completes.
- `i_f_valid`, in, 1: fetch request.
- `i_f_addr`, in, 21: fetch byte address.
- `o_f_data`, out, 8: fetched instruction byte.
- `i_d_valid`, in, 1: data access request.
- `i_d_we`, in, 1: data write enable.
- `i_d_addr`, in, 19: data word address (byte address bits [20:2]).
- `i_d_data`, in, 32: store data.
- `o_d_data`, out, 32: load data.
- `o_err`, out, 1: sticky out-of-range flag; present only with the bounds-check option, otherwise tied 0.

## Operation

- Storage is an array of `DEPTH_WORDS` 32-bit words and is little-endian: byte address `a` maps to word `a>>2`, lane `a[1:0]`, bits `[8*lane+7 : 8*lane]`.
- Loader FSM states:
  - `LEN`: accept 4 bytes, forming a 32-bit byte count `N`, least-significant byte first. After the 4th byte: if `N`==0, go to `DONE`; else go to `DATA`.
  - `DATA`: byte `k` (k = 0..N-1) is written to byte address `k` using a single-lane byte write. After byte `N-1` is accepted, go to `DONE`.
  - `DONE`: terminal state; exit only via reset.
- `o_ld_ready` is 1 in `LEN` and `DATA`, and 0 in `DONE`. A byte transfers on a rising edge with `i_ld_valid & o_ld_ready`. `i_ld_data` is ignored when `i_ld_valid` is 0.
- `o_ld_done` = (state == `DONE`). `o_cpu_rst` = !(state == `DONE`). Both are registered, derived from the state register.
- Fetch: `o_f_data` = the byte at `i_f_addr`, combinational. `i_f_valid` does not gate the output.
- Data read: `o_d_data` = `mem[i_d_addr]`, combinational.
- Data write: on the rising edge, when `i_d_valid & i_d_we & o_ld_done`, the full word is written. Writes while not `o_ld_done` are discarded.
- Index arithmetic: the word index is the address modulo `DEPTH_WORDS`; upper bits are ignored. The byte counter is 32 bits and never wraps within a legal image.
- Reset mid-load: FSM returns to `LEN`, length and byte counters clear, `o_cpu_rst`=1. Memory contents are not cleared. A partially loaded image is simply overwritten by the next load.

## Timing

- Reset values:
  - `o_ld_ready`=1
  - `o_ld_done`=0
  - `o_cpu_rst`=1
  - `o_err`=0
  - `o_f_data` and `o_d_data` reflect array contents (undefined before load).
- Fetch and load latency is 0 cycles (combinational), matching the processor's single-cycle execute.
- Store latency: data written at edge T is visible on `o_d_data` and `o_f_data` after edge T. Read-during-write in the same cycle returns the old data.
- Completion:
  - When the final byte (or the 4th length byte with `N`=0) is accepted at edge T, `o_ld_ready` falls and `o_ld_done`/`o_cpu_rst` change after edge T.
  - The processor's first fetch is from address 0 in the cycle after T.
- Back-to-back: one byte per cycle is sustained with `i_ld_valid` held at 1.

## Configuration

- `HEX_MEMORY_BOUNDS_CHECK_EN` defined:
  - `o_err` sets (sticky until reset) on any accepted load byte, fetch with `i_f_valid`, or data access with `i_d_valid` whose word index is ≥ `DEPTH_WORDS`.
  - Out-of-range writes are suppressed.
  - Out-of-range reads return 0.
- Undefined: addresses wrap modulo `DEPTH_WORDS`, and `o_err` is constant 0.

## Test plan

- Reset, then stream length 0x00000005 followed by bytes 0x31,0x42,0x53,0x64,0x75 → `o_ld_done`=1 and `o_cpu_rst`=0 one edge after the 9th byte; `o_d_data` at addr 0 = 0x64534231; `o_f_data` at byte addr 4 = 0x75.
- Length 0 (bytes 00 00 00 00) → `DONE` after the 4th byte; `o_ld_ready`=0; further `i_ld_valid` pulses change nothing.
- After load, store 0xDEADBEEF to word 3 → next cycle `o_d_data`=0xDEADBEEF; fetch at byte addr 12 = 0xEF, at byte addr 15 = 0xDE.
- During `DATA`, drive `i_d_we`=1 with 0xFFFFFFFF to word 0 → word 0 retains loader bytes.
- Assert `i_rst_n`=0 after 2 of 5 data bytes → state `LEN`, `o_cpu_rst`=1; reload with a 1-byte image 0xAA → word 0 = 0x000042AA, so bytes 1 and 2 keep their old values (0x42, 0x00).
- With the macro defined and `DEPTH_WORDS`=16, store to word 20 → `o_err`=1 and the stored value is not written; without the macro, word 4 = stored value.
